// File: rtl/gen_scheduler.sv
// gen_scheduler: interleaves two en/valid/data value generators into one
// ready/valid stream through a small source-tagged first-word-fall-through
// buffer. Generator enables are throttled against buffer occupancy plus the
// value still in flight, so compliant sources can never overflow the buffer.
module gen_scheduler #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int SLICE = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [1:0]                   mode,
  output logic                         en0,
  input  logic                         valid0,
  input  logic [DW-1:0]                data0,
  output logic                         en1,
  input  logic                         valid1,
  input  logic [DW-1:0]                data1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic                         out_src,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy,
  output logic                         ovf
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SLICE + 1);

  localparam logic [LW:0]   DEPTH_EXT = (LW + 1)'(DEPTH);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [CW-1:0] SLICE_END = CW'(SLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SWITCH = 2'd2
  } state_e;

  // Scheduler state
  state_e        state_q, state_d;
  logic          cur_q, cur_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          pend_src_q, pend_src_d;

  // Buffer state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] mem_data [DEPTH];
  logic          mem_src  [DEPTH];

  logic          issue;
  logic          room;
  logic          round_robin;
  logic [LW:0]   inflight;
  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [DW-1:0] push_data;

  // Committed words plus the value that will land at the end of this cycle.
  assign inflight    = {1'b0, level_q} + {{LW{1'b0}}, pend_q};
  assign room        = inflight < DEPTH_EXT;
  assign round_robin = mode_q[1];

  // Next-state and enable issue for the IDLE/RUN/SWITCH sequencer
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cur_d   = cur_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          mode_d  = mode;
          cur_d   = (mode == 2'd1);
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (room) begin
          issue = 1'b1;
          if (cnt_q == SLICE_END) begin
            cnt_d = '0;
            if (round_robin) state_d = S_SWITCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SWITCH: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          cur_d   = ~cur_q;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign en0        = issue & ~cur_q;
  assign en1        = issue & cur_q;
  assign pend_d     = issue;
  assign pend_src_d = cur_q;

  // A returned value is only accepted from the source that was enabled last cycle.
  assign push      = pend_q & (pend_src_q ? valid1 : valid0);
  assign push_data = pend_src_q ? data1 : data0;
  assign pop       = out_valid & out_ready;
  assign full      = (level_q == DEPTH_LVL);
  assign wr_en     = push & (~full | pop);

  // Buffer pointer, occupancy and sticky overflow update
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q | (push & full & ~pop);
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= S_IDLE;
      cur_q      <= 1'b0;
      mode_q     <= 2'd0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_src_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_src_q <= pend_src_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  // Buffer storage write port
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy is, and the head is gated to zero while empty.
    if (wr_en) begin
      mem_data[wr_ptr_q] <= push_data;
      mem_src[wr_ptr_q]  <= pend_src_q;
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
  assign out_src   = out_valid ? mem_src[rd_ptr_q] : 1'b0;
  assign level     = level_q;
  assign busy      = (state_q != S_IDLE) | pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// tb_gen_scheduler: drives gen_scheduler with two counting generators and
// checks every cycle against a queue-based behavioural model, plus literal
// expectations for the directed scenarios.
module tb_gen_scheduler;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int SLICE = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop;
  logic [1:0]    mode;
  logic          en0, en1;
  logic          valid0, valid1;
  logic [DW-1:0] data0, data1;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_src;
  logic [2:0]    level;
  logic          busy, ovf;

  gen_scheduler #(.DW(DW), .DEPTH(DEPTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .en0(en0), .valid0(valid0), .data0(data0),
    .en1(en1), .valid1(valid1), .data1(data1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .level(level), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            src;
    logic [DW-1:0] data;
  } word_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model
  word_t mq[$];
  int    m_state;   // 0 idle, 1 run, 2 switch
  bit    m_cur;
  int    m_mode;
  int    m_cnt;
  bit    m_pend, m_psrc, m_ovf;

  // Stimulus knobs, applied at the next negedge
  bit k_start, k_stop, k_rst, k_spur0, k_spur1, k_ready;
  int k_mode;

  // Generators: respond one cycle after their enable with the next count
  int s0_cnt, s1_cnt;
  bit last_en0, last_en1;

  // Snapshot of DUT outputs in the most recent step
  bit         s_en0, s_en1, s_out_valid, s_busy, s_ovf;
  logic [2:0] s_level;
  logic [15:0] s_out_data;
  word_t      pq[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_state = 0; m_cur = 0; m_mode = 0; m_cnt = 0;
    m_pend = 0; m_psrc = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge(bit issue);
    bit    push, pop;
    word_t w;
    int    sz;
    sz   = mq.size();
    push = m_pend && (m_psrc ? valid1 : valid0);
    pop  = (sz != 0) && out_ready;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (sz == DEPTH && !pop) m_ovf = 1;
      else begin
        w.src  = m_psrc;
        w.data = m_psrc ? data1 : data0;
        mq.push_back(w);
      end
    end
    m_pend = issue;
    m_psrc = m_cur;
    case (m_state)
      0: if (start && !stop) begin
           m_state = 1; m_mode = int'(mode); m_cur = (mode == 2'd1); m_cnt = 0;
         end
      1: if (stop) m_state = 0;
         else if (issue) begin
           m_cnt++;
           if (m_cnt == SLICE) begin
             m_cnt = 0;
             if (m_mode >= 2) m_state = 2;
           end
         end
      2: if (stop) m_state = 0;
         else begin m_cur = !m_cur; m_state = 1; end
      default: m_state = 0;
    endcase
  endfunction

  task automatic step();
    bit    e_issue;
    int    lvl;
    word_t w;
    @(negedge clk);
    cyc++;
    rst = k_rst;
    if (k_rst) begin
      s0_cnt = 0; s1_cnt = 0; last_en0 = 0; last_en1 = 0;
      model_reset();
    end
    if (last_en0) begin s0_cnt++; valid0 = 1'b1; data0 = 16'(s0_cnt); end
    else if (k_spur0) begin valid0 = 1'b1; data0 = 16'hBEEF; end
    else begin valid0 = 1'b0; data0 = 16'($urandom); end
    if (last_en1) begin s1_cnt++; valid1 = 1'b1; data1 = 16'h8000 + 16'(s1_cnt); end
    else if (k_spur1) begin valid1 = 1'b1; data1 = 16'hBEEF; end
    else begin valid1 = 1'b0; data1 = 16'($urandom); end
    start = k_start; stop = k_stop; mode = 2'(k_mode); out_ready = k_ready;
    k_start = 0; k_stop = 0; k_spur0 = 0; k_spur1 = 0;
    #1;
    lvl     = mq.size();
    e_issue = !k_rst && m_state == 1 && !stop && (lvl + int'(m_pend) < DEPTH);
    check("en0", en0, e_issue && !m_cur);
    check("en1", en1, e_issue && m_cur);
    check("out_valid", out_valid, lvl != 0);
    check("out_data", out_data, (lvl != 0) ? mq[0].data : 16'h0);
    check("out_src", out_src, (lvl != 0) ? mq[0].src : 1'b0);
    check("level", level, lvl);
    check("busy", busy, m_state != 0 || m_pend);
    check("ovf", ovf, m_ovf);
    s_en0 = en0; s_en1 = en1; s_out_valid = out_valid; s_busy = busy;
    s_ovf = ovf; s_level = level; s_out_data = out_data;
    if (out_valid && out_ready) begin
      w.src = out_src; w.data = out_data; pq.push_back(w);
    end
    last_en0 = en0;
    last_en1 = en1;
    if (!k_rst) model_edge(e_issue);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    k_rst = 1; run(2); k_rst = 0;
    cyc = 0;
    pq.delete();
  endtask

  task automatic stop_and_drain();
    k_stop = 1; k_ready = 1; run(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int pops;
    rst = 1; start = 0; stop = 0; mode = 0; out_ready = 0;
    valid0 = 0; valid1 = 0; data0 = 0; data1 = 0;
    k_start = 0; k_stop = 0; k_spur0 = 0; k_spur1 = 0; k_ready = 0; k_mode = 0;
    s0_cnt = 0; s1_cnt = 0; last_en0 = 0; last_en1 = 0;
    model_reset();

    // Single source, start at cycle 10
    do_reset();
    k_mode = 0; k_ready = 1;
    repeat (30) begin
      k_start = (cyc == 9);
      step();
      if (cyc == 10) check("t1_en0_c10", s_en0, 0);
      if (cyc == 11) check("t1_en0_c11", s_en0, 1);
      if (cyc == 12) check("t1_ovalid_c12", s_out_valid, 0);
      if (cyc == 13) begin
        check("t1_ovalid_c13", s_out_valid, 1);
        check("t1_data_c13", s_out_data, 16'd1);
      end
      if (cyc == 14) check("t1_data_c14", s_out_data, 16'd2);
      if (cyc == 15) check("t1_data_c15", s_out_data, 16'd3);
    end
    stop_and_drain();

    // Round robin slicing
    do_reset();
    k_mode = 2; k_ready = 1; k_start = 1;
    run(60);
    check("t2_count", pq.size() >= 17, 1);
    if (pq.size() >= 17) begin
      for (int i = 0; i < 8; i++) begin
        check("t2_src0_data", pq[i].data, 16'(i + 1));
        check("t2_src0_tag", pq[i].src, 0);
        check("t2_src1_data", pq[i+8].data, 16'h8000 + 16'(i + 1));
        check("t2_src1_tag", pq[i+8].src, 1);
      end
      check("t2_resume_data", pq[16].data, 16'd9);
      check("t2_resume_tag", pq[16].src, 0);
    end
    stop_and_drain();

    // Backpressure fills the buffer exactly
    do_reset();
    k_mode = 0; k_ready = 0; k_start = 1;
    run(12);
    check("t3_level_full", s_level, 4);
    check("t3_ovf", s_ovf, 0);
    check("t3_en0_throttled", s_en0, 0);
    check("t3_head", s_out_data, 16'd1);
    check("t3_issued", s0_cnt, 4);
    pq.delete();
    k_ready = 1;
    run(20);
    check("t3_count", pq.size() >= 10, 1);
    foreach (pq[i]) check("t3_seq", pq[i].data, 16'(i + 1));
    stop_and_drain();

    // Stop with a value in flight
    do_reset();
    k_mode = 0; k_ready = 1; k_start = 1;
    run(8);
    check("t4_pre_en0", s_en0, 1);
    k_stop = 1;
    step();
    check("t4_stop_en0", s_en0, 0);
    check("t4_stop_busy", s_busy, 1);
    step();
    check("t4_idle_busy", s_busy, 0);
    run(6);
    check("t4_drained", s_level, 0);
    check("t4_all_words", pq.size(), s0_cnt);
    if (pq.size() > 0) check("t4_last_word", pq[pq.size()-1].data, 16'(s0_cnt));

    // Unsolicited valids are ignored
    do_reset();
    k_mode = 0; k_ready = 1; k_start = 1;
    repeat (20) begin k_spur1 = 1'($urandom_range(0, 1)); step(); end
    stop_and_drain();
    bad = 0;
    foreach (pq[i]) if (pq[i].src != 0 || pq[i].data == 16'hBEEF) bad++;
    check("t5_src0_clean", bad, 0);
    check("t5_src0_count", pq.size(), s0_cnt);
    do_reset();
    k_mode = 1; k_ready = 1; k_start = 1;
    repeat (20) begin k_spur0 = 1'($urandom_range(0, 1)); step(); end
    stop_and_drain();
    bad = 0;
    foreach (pq[i]) if (pq[i].src != 1 || pq[i].data == 16'hBEEF) bad++;
    check("t5_src1_clean", bad, 0);
    check("t5_src1_count", pq.size(), s1_cnt);

    // Reset in the middle of a run
    do_reset();
    k_mode = 0; k_ready = 0; k_start = 1;
    for (int i = 0; i < 20 && s_level != 3; i++) step();
    check("t6_reach3", s_level, 3);
    k_rst = 1;
    step();
    check("t6_level", s_level, 0);
    check("t6_ovalid", s_out_valid, 0);
    check("t6_en0", s_en0, 0);
    check("t6_en1", s_en1, 0);
    check("t6_ovf", s_ovf, 0);
    check("t6_busy", s_busy, 0);
    k_rst = 0;
    step();
    pq.delete();
    k_ready = 1; k_start = 1;
    run(10);
    check("t6_resume", pq.size() > 0, 1);
    if (pq.size() > 0) check("t6_resume_first", pq[0].data, 16'd1);
    stop_and_drain();

    // Randomized traffic with stall phases and occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      k_ready = (((i / 50) % 3) == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      k_mode  = $urandom_range(0, 3);
      k_start = ($urandom_range(0, 15) == 0);
      k_stop  = ($urandom_range(0, 39) == 0);
      k_spur0 = ($urandom_range(0, 7) == 0);
      k_spur1 = ($urandom_range(0, 7) == 0);
      k_rst   = ($urandom_range(0, 699) == 0);
      step();
    end
    k_rst = 0;
    pops = pq.size();
    stop_and_drain();
    check("rand_drained", s_level, 0);
    check("rand_no_ovf", s_ovf, 0);
    check("rand_traffic", pops > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gen_scheduler.md
Name: gen_scheduler

Overview:
Sequencer that shares one output stream between two value generators: source 0 is the timer counter and source 1 is a second generator with the same en/valid/data contract. It drives each generator's enable, captures the returned values into a small first-word-fall-through buffer tagged with the source, and presents them on a ready/valid output. Enables are throttled so that the buffer never overflows under backpressure.

Parameters:
DW, 16, data width of generator outputs and out_data
DEPTH, 4, buffer entries (power of two, >=2)
SLICE, 8, enables issued to one source before switching in round-robin mode

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle pulse; begins scheduling (ignored unless IDLE)
stop  in  1  one-cycle pulse; ends scheduling
mode  in  2  0=source0 only, 1=source1 only, 2/3=round robin starting at source0
en0  out  1  enable to source 0
valid0  in  1  source 0 value valid (one cycle after en0)
data0  in  DW  source 0 value
en1  out  1  enable to source 1
valid1  in  1  source 1 value valid
data1  in  DW  source 1 value
out_valid  out  1  buffer head valid
out_ready  in  1  consumer accepts head
out_data  out  DW  buffer head value
out_src  out  1  buffer head source tag
level  out  $clog2(DEPTH+1)  buffer occupancy
busy  out  1  state!=IDLE or pend=1
ovf  out  1  sticky: a write was dropped because the buffer was full

Behaviour:
- Reset: state IDLE, en0=en1=0, pend=0, level=0, out_valid=0, out_data=0, out_src=0, ovf=0, busy=0, slice count 0. Reset mid-operation discards buffer contents and any in-flight value.
- States: IDLE, RUN, SWITCH. cur is the registered active source.
- IDLE: start=1 -> RUN; mode latched into mode_r; cur=1 if mode=1, else 0; slice count cleared.
- RUN: en_cur = (level + pend) < DEPTH and stop=0; the other enable is 0. Each issued enable increments the slice count. In round-robin mode, the cycle that issues enable number SLICE -> SWITCH, and the count is cleared.
- SWITCH: lasts exactly one cycle with both enables 0; cur toggles, then -> RUN.
- stop=1 in RUN/SWITCH: enables are forced to 0 in that same cycle (combinational), and the state goes -> IDLE. start and stop in the same cycle: stop wins. start outside IDLE is ignored.
- pend/pend_src register the previous cycle's issued enable and its source.
- Capture: a write occurs when pend=1 and valid[pend_src]=1, with data[pend_src] tagged pend_src. It is accepted in any state, including IDLE right after stop. Any valid without a matching pend is ignored.
- Buffer: FWFT. out_valid = level!=0. Pop when out_valid and out_ready. Simultaneous push and pop keep level unchanged and are legal when full.
- Full: a push with level=DEPTH and no pop is dropped and sets ovf. The throttle rule guarantees ovf stays 0 with compliant sources.
- Latency: start sampled at edge k; en high in cycle k+1; valid in k+2; out_valid in k+3 when the buffer was empty.
- Data is passed unmodified; no arithmetic on DW. level never exceeds DEPTH.

Test Plan:
- mode=0, out_ready=1, source 0 is the timer from reset, start at cycle 10 -> en0 high from cycle 11; out_valid from cycle 13 with out_src=0, out_data=1,2,3,... consecutive; en1 stays 0.
- mode=2, SLICE=8, out_ready=1 -> 8 words src0 (1..8), 1-cycle gap, 8 words src1, then src0 resumes at 9; no duplicates or losses.
- mode=0, out_ready=0 after start -> level rises to exactly 4; en0 drops so the 4 words are 1..4; ovf=0. Raise out_ready -> stream continues with 5,6,... and no gaps in value.
- stop during RUN while pend=1 -> en0=0 in the stop cycle; the pending value is still written; busy falls the cycle after; the buffer drains fully.
- mode=0 with valid1 pulsed (data1=16'hBEEF) -> no write and level unchanged; mode=1 symmetric with valid0.
- rst asserted mid-run with level=3 -> next cycle level=0, out_valid=0, en0=en1=0, ovf=0, state IDLE; a subsequent start resumes normally.
